// File: rtl/mux_rr_arbiter_pkg.sv
// Shared helpers and default parameters for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 8;

  // Index width, never below one bit so a two-requester build still has a select.
  function automatic int unsigned rr_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester and consumer handshake bundle for mux_rr_arbiter.
interface mux_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  localparam int unsigned IdxW = rr_idx_w(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic                    out_ready;
  logic [IdxW-1:0]         out_grant;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_grant
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_grant
  );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned IDX_W = rr_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             any_o
);

  logic             found;
  int unsigned      idx;
  logic [IDX_W-1:0] sel;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    sel      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_ptr_i) + k) % N_REQ;
      sel = IDX_W'(idx);
      if (!found && req_valid_i[sel]) begin
        found    = 1'b1;
        winner_o = sel;
      end
    end
    any_o = |req_valid_i;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin N-to-1 mux with one registered output slot.
// Optional MUX_RR_ARBITER_STALL_CNT_EN adds a saturating stall counter output.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
`ifdef MUX_RR_ARBITER_STALL_CNT_EN
  output logic [15:0]        stall_cnt_o,
`endif
  mux_rr_arbiter_if.slave    bus
);

  localparam int unsigned IdxW = rr_idx_w(N_REQ);

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [IdxW-1:0]   out_grant_q;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   winner;
  logic              any;
  logic              free;
  logic              accept;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IdxW)
  ) u_rr_pick (
    .req_valid_i (bus.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .winner_o    (winner),
    .any_o       (any)
  );

  // Slot can refill in the same cycle it drains, giving one word per cycle.
  assign free   = !out_valid_q || bus.out_ready;
  assign accept = free && any && !rst;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[winner] = 1'b1;
    rr_ptr_d = (32'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_grant_q <= '0;
      rr_ptr_q    <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.req_data[32'(winner)*DATA_W +: DATA_W];
      out_grant_q <= winner;
      rr_ptr_q    <= rr_ptr_d;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_grant = out_grant_q;

`ifdef MUX_RR_ARBITER_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !bus.out_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
